wb_dbus_master: RTL

- Bridges the rv32i core's memory-stage data port to a Wishbone B4 classic bus as the single master controller for data accesses.
- Converts each core load/store into one Wishbone cycle, holding the pipeline via stall_pipl until ack, error or timeout.
- Generates byte lanes from mem_op, aligns and sign/zero-extends load data, and reports misaligned and failed accesses.
- Sits between the core top (mem_*_mem ports, stall_pipl) and the SoC Wishbone interconnect (UART, SPI, DMEM).

---
 rtl/wb_dbus_pkg.sv | 32 +++
 rtl/wb_dbus_master_if.sv | 30 +++
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/wb_dbus_master.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/wb_dbus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_dbus_pkg
// Purpose : Shared types, funct3 encodings and alignment check for the
//           core data-port Wishbone master.
// Revision: 1.0
// ============================================================================
package wb_dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // Undefined funct3 encodings fall into the word case.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            MEM_B, MEM_BU: return 1'b0;
            MEM_H, MEM_HU: return addr_lo[0];
            default:       return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_dbus_master_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_dbus_master_if
// Purpose : Wishbone B4 classic signal bundle between data master and fabric.
// Revision: 1.0
// ============================================================================
interface wb_dbus_master_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] wb_adr_o;
    logic [31:0]       wb_dat_o;
    logic [3:0]        wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic [31:0]       wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_lane_align
// Purpose : Byte-lane select, store replication and load extraction/extension.
// Revision: 1.0
// ============================================================================
module lsu_lane_align
    import wb_dbus_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] w_shift;

    always_comb begin
        w_shift   = rdata_raw >> {addr_lo, 3'b000};
        sel       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata_raw;
        // op[2] distinguishes the unsigned load variants.
        case (op)
            MEM_B, MEM_BU: begin
                sel       = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{w_shift[7] & ~op[2]}}, w_shift[7:0]};
            end
            MEM_H, MEM_HU: begin
                sel       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{w_shift[15] & ~op[2]}}, w_shift[15:0]};
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_dbus_master.sv
`default_nettype none
// ============================================================================
// Module  : wb_dbus_master
// Purpose : Core memory-stage data port to Wishbone B4 classic master bridge.
// Revision: 1.0
// ============================================================================
module wb_dbus_master
    import wb_dbus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic                    mem_write,
    input  logic                    mem_read,
    input  logic [2:0]              mem_op,
    output logic [31:0]             mem_rdata,
    output logic                    stall_pipl,
    wb_dbus_master_if.master        wb,
    output logic                    bus_err_o,
    output logic                    misalign_o,
    output logic [31:0]             err_addr_o
);

    localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYCLES - 1);

    state_t            r_state, w_state_n;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_dat;
    logic [3:0]        r_sel;
    logic              r_we;
    logic              r_cyc;
    logic [2:0]        r_op;
    logic [1:0]        r_lane;
    logic [31:0]       r_addr;
    logic [15:0]       r_cnt;
    logic [31:0]       r_rdata;
    logic              r_bus_err;
    logic              r_misalign;
    logic [31:0]       r_err_addr;

    logic              w_req;
    logic              w_misalign;
    logic              w_launch;
    logic              w_reject;
    logic              w_ok;
    logic              w_fault;
    logic [2:0]        w_al_op;
    logic [1:0]        w_al_lane;
    logic [3:0]        w_sel;
    logic [31:0]       w_wdata_rep;
    logic [31:0]       w_rdata_ext;

    assign w_req      = mem_read | mem_write;
    assign w_misalign = is_misaligned(mem_op, mem_addr[1:0]);

    // One aligner serves both directions: request fields in IDLE, load data in BUS.
    assign w_al_op   = (r_state == IDLE) ? mem_op        : r_op;
    assign w_al_lane = (r_state == IDLE) ? mem_addr[1:0] : r_lane;

    lsu_lane_align u_align (
        .op        (w_al_op),
        .addr_lo   (w_al_lane),
        .wdata     (mem_wdata),
        .rdata_raw (wb.wb_dat_i),
        .sel       (w_sel),
        .wdata_rep (w_wdata_rep),
        .rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        stall_pipl = 1'b0;
        w_launch   = 1'b0;
        w_reject   = 1'b0;
        w_ok       = 1'b0;
        w_fault    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    stall_pipl = 1'b1;
                    if (w_misalign) begin
                        w_reject  = 1'b1;
                        w_state_n = DONE;
                    end else begin
                        w_launch  = 1'b1;
                        w_state_n = BUS;
                    end
                end
            end
            BUS: begin
                stall_pipl = 1'b1;
                if (wb.wb_ack_i) begin
                    w_ok      = 1'b1;
                    w_state_n = DONE;
                end else if (wb.wb_err_i || (r_cnt == c_to_last)) begin
                    w_fault   = 1'b1;
                    w_state_n = DONE;
                end
            end
            DONE: begin
                // The request still on the port here is the one just retired.
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_adr      <= '0;
            r_dat      <= '0;
            r_sel      <= '0;
            r_we       <= 1'b0;
            r_cyc      <= 1'b0;
            r_op       <= '0;
            r_lane     <= '0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_bus_err  <= 1'b0;
            r_misalign <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_bus_err  <= 1'b0;
            r_misalign <= 1'b0;
            r_cnt      <= (r_state == BUS && w_state_n == BUS) ? r_cnt + 16'd1 : 16'd0;
            if (w_launch || w_reject) begin
                r_adr  <= ADDR_W'({mem_addr[31:2], 2'b00});
                r_dat  <= w_wdata_rep;
                r_sel  <= w_sel;
                r_we   <= mem_write;
                r_op   <= mem_op;
                r_lane <= mem_addr[1:0];
                r_addr <= mem_addr;
            end
            if (w_launch) begin
                r_cyc <= 1'b1;
            end
            if (w_reject) begin
                r_misalign <= 1'b1;
                r_err_addr <= mem_addr;
                r_rdata    <= '0;
            end
            if (w_ok) begin
                r_cyc <= 1'b0;
                if (!r_we) begin
                    r_rdata <= w_rdata_ext;
                end
            end
            if (w_fault) begin
                r_cyc      <= 1'b0;
                r_bus_err  <= 1'b1;
                r_err_addr <= r_addr;
                r_rdata    <= '0;
            end
        end
    end

    assign wb.wb_adr_o = r_adr;
    assign wb.wb_dat_o = r_dat;
    assign wb.wb_sel_o = r_sel;
    assign wb.wb_we_o  = r_we;
    assign wb.wb_cyc_o = r_cyc;
    assign wb.wb_stb_o = r_cyc;
    assign mem_rdata   = r_rdata;
    assign bus_err_o   = r_bus_err;
    assign misalign_o  = r_misalign;
    assign err_addr_o  = r_err_addr;

endmodule
`default_nettype wire
